// File: rtl/bmc_soft_pipe.sv
// Two-stage branch-metric unit: soft/hard per-slot distances with erasure and
// periodic depuncturing, then one summed metric per expected code pattern.
module bmc_soft_pipe #(
  parameter int SOFT_W    = 3,
  parameter int N_OUT     = 2,
  parameter int PUNCT_LEN = 1,
  parameter logic [PUNCT_LEN*N_OUT-1:0] PUNCT_PAT = {(PUNCT_LEN*N_OUT){1'b1}},
  localparam int BM_W = SOFT_W + $clog2(N_OUT),
  localparam int N_BM = 1 << N_OUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hard_mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sof,
  input  logic [N_OUT*SOFT_W-1:0]  in_rx,
  input  logic [N_OUT-1:0]         in_erase,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sof,
  output logic [N_BM*BM_W-1:0]     out_bm
);

  localparam int PH_W = (PUNCT_LEN > 1) ? $clog2(PUNCT_LEN) : 1;
  localparam logic [SOFT_W-1:0] SOFT_MAX = {SOFT_W{1'b1}};

  logic [PH_W-1:0]           ph_q, ph_d, used_ph_s;
  logic                      s1_valid_q, s1_sof_q;
  logic [N_OUT*SOFT_W-1:0]   d0_q, d1_q, d0_d, d1_d;
  logic                      out_valid_q, out_sof_q;
  logic [N_BM*BM_W-1:0]      bm_q, bm_d;
  logic                      s2_load_s, s1_load_s, accept_s;
  logic [SOFT_W-1:0]         r_s, d0_s, d1_s;
  logic                      h_s, erased_s;
  logic [BM_W-1:0]           acc_s;

  // Handshake: each stage advances when the stage after it has room.
  always_comb begin
    s2_load_s = !out_valid_q || out_ready;
    s1_load_s = !s1_valid_q || s2_load_s;
    accept_s  = in_valid && s1_load_s;
  end

  // Puncture phase: in_sof restarts at 0, otherwise step and wrap per accepted symbol.
  always_comb begin
    if (in_sof) begin
      used_ph_s = {PH_W{1'b0}};
    end else begin
      used_ph_s = ph_q;
    end
    if (accept_s) begin
      if (used_ph_s == PH_W'(PUNCT_LEN - 1)) begin
        ph_d = {PH_W{1'b0}};
      end else begin
        ph_d = used_ph_s + PH_W'(1);
      end
    end else begin
      ph_d = ph_q;
    end
  end

  // Per-slot distances; erased or punctured slots contribute nothing to any metric.
  always_comb begin
    d0_d     = {(N_OUT*SOFT_W){1'b0}};
    d1_d     = {(N_OUT*SOFT_W){1'b0}};
    r_s      = {SOFT_W{1'b0}};
    d0_s     = {SOFT_W{1'b0}};
    d1_s     = {SOFT_W{1'b0}};
    h_s      = 1'b0;
    erased_s = 1'b0;
    for (int i = 0; i < N_OUT; i++) begin
      r_s      = in_rx[i*SOFT_W +: SOFT_W];
      h_s      = r_s[SOFT_W-1];
      erased_s = in_erase[i] | ~PUNCT_PAT[int'(used_ph_s)*N_OUT + i];
      d0_s     = {SOFT_W{1'b0}};
      d1_s     = {SOFT_W{1'b0}};
      if (erased_s) begin
        d0_s = {SOFT_W{1'b0}};
        d1_s = {SOFT_W{1'b0}};
      end else if (hard_mode) begin
        d0_s[0] = h_s;
        d1_s[0] = ~h_s;
      end else begin
        d0_s = r_s;
        d1_s = SOFT_MAX - r_s;
      end
      d0_d[i*SOFT_W +: SOFT_W] = d0_s;
      d1_d[i*SOFT_W +: SOFT_W] = d1_s;
    end
  end

  // Metric j picks d1 for slots where bit i of j is set, d0 elsewhere.
  always_comb begin
    bm_d  = {(N_BM*BM_W){1'b0}};
    acc_s = {BM_W{1'b0}};
    for (int j = 0; j < N_BM; j++) begin
      acc_s = {BM_W{1'b0}};
      for (int i = 0; i < N_OUT; i++) begin
        if (((j >> i) & 1) != 0) begin
          acc_s = acc_s + BM_W'(d1_q[i*SOFT_W +: SOFT_W]);
        end else begin
          acc_s = acc_s + BM_W'(d0_q[i*SOFT_W +: SOFT_W]);
        end
      end
      bm_d[j*BM_W +: BM_W] = acc_s;
    end
  end

  // Stage 1: phase register and erasure-applied distances.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph_q       <= {PH_W{1'b0}};
      s1_valid_q <= 1'b0;
      s1_sof_q   <= 1'b0;
      d0_q       <= {(N_OUT*SOFT_W){1'b0}};
      d1_q       <= {(N_OUT*SOFT_W){1'b0}};
    end else begin
      ph_q <= ph_d;
      if (s1_load_s) begin
        s1_valid_q <= in_valid;
        if (accept_s) begin
          s1_sof_q <= in_sof;
          d0_q     <= d0_d;
          d1_q     <= d1_d;
        end
      end
    end
  end

  // Stage 2: summed metrics, held stable while downstream stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      bm_q        <= {(N_BM*BM_W){1'b0}};
    end else if (s2_load_s) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_sof_q <= s1_sof_q;
        bm_q      <= bm_d;
      end
    end
  end

  assign in_ready  = s1_load_s;
  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_bm    = bm_q;

endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Bench for bmc_soft_pipe: default instance plus a punctured instance
// (PUNCT_LEN=2, PUNCT_PAT=4'b0111) sharing the same input stream.
module tb_bmc_soft_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        hard_mode, in_valid, in_sof, out_ready;
  logic [5:0]  in_rx;
  logic [1:0]  in_erase;
  logic        in_ready, out_valid, out_sof;
  logic [15:0] out_bm;
  logic        p_in_ready, p_out_valid, p_out_sof;
  logic [15:0] p_out_bm;

  int total = 0;
  int bad   = 0;

  typedef struct { logic [15:0] bm; logic sof; } exp_t;
  exp_t q_a[$];
  exp_t q_p[$];
  exp_t ea, ep;
  int   ph_a = 0;
  int   ph_p = 0;

  typedef struct { logic [5:0] rx; logic [1:0] er; logic hard; logic [15:0] exp_bm; } vec_t;
  vec_t vt[9];

  int          sent;
  logic [15:0] hold_bm;
  logic [5:0]  bp_rx[5];
  int          exp_m0[6];
  logic [5:0]  sofs;

  always #5 clk = ~clk;

  bmc_soft_pipe u_dut (
    .clk(clk), .rst(rst), .hard_mode(hard_mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_sof(in_sof), .in_rx(in_rx), .in_erase(in_erase), .out_valid(out_valid),
    .out_ready(out_ready), .out_sof(out_sof), .out_bm(out_bm)
  );

  bmc_soft_pipe #(.PUNCT_LEN(2), .PUNCT_PAT(4'b0111)) u_pdut (
    .clk(clk), .rst(rst), .hard_mode(hard_mode), .in_valid(in_valid), .in_ready(p_in_ready),
    .in_sof(in_sof), .in_rx(in_rx), .in_erase(in_erase), .out_valid(p_out_valid),
    .out_ready(out_ready), .out_sof(p_out_sof), .out_bm(p_out_bm)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: metric j = sum over transmitted, non-erased slots of distance to bit i of j.
  function automatic logic [15:0] model_bm(input logic [5:0] rx, input logic [1:0] er,
                                           input logic hard, input int phase, input logic [3:0] pat);
    logic [15:0] res;
    res = 16'd0;
    for (int j = 0; j < 4; j++) begin
      int s;
      s = 0;
      for (int i = 0; i < 2; i++) begin
        int r;
        int b;
        r = int'(rx[i*3 +: 3]);
        b = (j >> i) & 1;
        if (er[i] == 1'b0 && pat[phase*2 + i] == 1'b1) begin
          if (hard) s += ((r >= 4) ? 1 : 0) ^ b;
          else      s += (b == 1) ? (7 - r) : r;
        end
      end
      res[j*4 +: 4] = 4'(s);
    end
    return res;
  endfunction

  // Scoreboard: sampled mid-cycle, pushes on acceptance, pops on output transfer.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      q_a.delete();
      q_p.delete();
      ph_a = 0;
      ph_p = 0;
    end else begin
      check("valid_match", 32'(p_out_valid), 32'(out_valid));
      check("ready_match", 32'(p_in_ready), 32'(in_ready));
      if (out_valid && out_ready) begin
        if (q_a.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_underflow: got=unexpected output expected=none at %0t", $time);
        end else begin
          ea = q_a.pop_front();
          check("sb_bm", 32'(out_bm), 32'(ea.bm));
          check("sb_sof", 32'(out_sof), 32'(ea.sof));
        end
      end
      if (p_out_valid && out_ready) begin
        if (q_p.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_p_underflow: got=unexpected output expected=none at %0t", $time);
        end else begin
          ep = q_p.pop_front();
          check("sb_p_bm", 32'(p_out_bm), 32'(ep.bm));
          check("sb_p_sof", 32'(p_out_sof), 32'(ep.sof));
        end
      end
      if (in_valid && in_ready) begin
        int u;
        u = in_sof ? 0 : ph_a;
        q_a.push_back('{bm: model_bm(in_rx, in_erase, hard_mode, u, 4'b0011), sof: in_sof});
        ph_a = (u + 1) % 1;
        u = in_sof ? 0 : ph_p;
        q_p.push_back('{bm: model_bm(in_rx, in_erase, hard_mode, u, 4'b0111), sof: in_sof});
        ph_p = (u + 1) % 2;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; hard_mode = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    out_ready = 1'b0; in_rx = 6'd0; in_erase = 2'd0;

    vt[0] = '{6'o07, 2'b00, 1'b0, {4'd7, 4'd14, 4'd0, 4'd7}};
    vt[1] = '{6'o07, 2'b00, 1'b1, {4'd1, 4'd2, 4'd0, 4'd1}};
    vt[2] = '{6'o23, 2'b00, 1'b1, {4'd2, 4'd1, 4'd1, 4'd0}};
    vt[3] = '{6'o14, 2'b00, 1'b1, {4'd1, 4'd2, 4'd0, 4'd1}};
    vt[4] = '{6'o50, 2'b00, 1'b1, {4'd1, 4'd0, 4'd2, 4'd1}};
    vt[5] = '{6'o76, 2'b00, 1'b1, {4'd0, 4'd1, 4'd1, 4'd2}};
    vt[6] = '{6'o07, 2'b01, 1'b0, {4'd7, 4'd7, 4'd0, 4'd0}};
    vt[7] = '{6'o07, 2'b11, 1'b0, 16'd0};
    vt[8] = '{6'o52, 2'b00, 1'b0, {4'd7, 4'd4, 4'd10, 4'd7}};

    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_bm", 32'(out_bm), 32'd0);
    check("rst_out_sof", 32'(out_sof), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // Directed vectors: one symbol at a time, two-cycle latency checked.
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_rx = vt[k].rx; in_erase = vt[k].er; hard_mode = vt[k].hard; in_sof = 1'b0;
      #1 check("vec_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #1 check("vec_lat1_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      #1;
      check("vec_lat2_valid", 32'(out_valid), 32'd1);
      check("vec_bm", 32'(out_bm), 32'(vt[k].exp_bm));
    end

    // Depuncturing with in_sof on symbols 1 and 4.
    sofs = 6'b001001;
    exp_m0[0] = 14; exp_m0[1] = 7; exp_m0[2] = 14; exp_m0[3] = 14; exp_m0[4] = 7; exp_m0[5] = 14;
    hard_mode = 1'b0; in_erase = 2'b00;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k < 6) begin
        in_valid = 1'b1; in_rx = 6'o77; in_sof = sofs[k];
      end else begin
        in_valid = 1'b0; in_sof = 1'b0;
      end
      #1;
      if (k >= 2) begin
        check("punct_valid", 32'(p_out_valid), 32'd1);
        check("punct_m0", 32'(p_out_bm[3:0]), 32'(exp_m0[k-2]));
      end
    end

    // Back-pressure: out_ready low for 4 cycles, then released.
    for (int k = 0; k < 5; k++) bp_rx[k] = 6'($urandom);
    sent = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      out_ready = (c >= 4);
      if (sent < 5) begin
        in_valid = 1'b1; in_rx = bp_rx[sent]; in_sof = (sent == 0);
      end else begin
        in_valid = 1'b0; in_sof = 1'b0;
      end
      #1;
      if (c < 4) check("bp_in_ready", 32'(in_ready), (c < 2) ? 32'd1 : 32'd0);
      if (c == 2) hold_bm = out_bm;
      if (c == 3) begin
        check("bp_stall_valid", 32'(out_valid), 32'd1);
        check("bp_stall_bm", 32'(out_bm), 32'(hold_bm));
      end
      if (c >= 4 && c <= 8) begin
        check("bp_stream_valid", 32'(out_valid), 32'd1);
        check("bp_stream_bm", 32'(out_bm), 32'(model_bm(bp_rx[c-4], 2'b00, 1'b0, 0, 4'b0011)));
      end
      if (c == 9) check("bp_drained", 32'(out_valid), 32'd0);
      if (in_valid && in_ready) sent++;
    end
    check("bp_sent", 32'(sent), 32'd5);

    // Reset with two symbols in flight; pdut phase is 1 when reset hits.
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_rx = 6'o77; in_sof = 1'b0;
    @(negedge clk);
    in_sof = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0;
    #1 check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_bm", 32'(out_bm), 32'd0);
    check("async_rst_p_bm", 32'(p_out_bm), 32'd0);
    check("async_rst_sof", 32'(out_sof), 32'd0);
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_rx = 6'o77; in_sof = 1'b0;
    #1 check("post_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("post_rst_lat1", 32'(p_out_valid), 32'd0);
    @(negedge clk);
    #1;
    check("post_rst_lat2", 32'(p_out_valid), 32'd1);
    check("post_rst_phase0_m0", 32'(p_out_bm[3:0]), 32'd14);

    // Randomized traffic against the scoreboard.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_rx     = 6'($urandom);
      in_erase  = 2'($urandom);
      hard_mode = 1'($urandom);
      in_sof    = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #3;
    check("sb_drain_a", 32'(q_a.size()), 32'd0);
    check("sb_drain_p", 32'(q_p.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
